// File: rtl/apu_frame_pkg.sv
// Shared constants, mode type and counter-encoding helpers for the APU frame counter.
// FRAME_LFSR_EN selects a 15-bit Fibonacci LFSR in place of the binary counter.
package apu_frame_pkg;

   localparam int CNT_W = 15;

   localparam int STEP1 = 3728;
   localparam int STEP2 = 7456;
   localparam int STEP3 = 11185;
   localparam int STEP4 = 14914;
   localparam int STEP5 = 18640;
   localparam int NUM_STEPS = 5;

   localparam logic [CNT_W-1:0] LFSR_SEED = 15'h7FFF;

   typedef enum logic {
      MODE_4STEP = 1'b0,
      MODE_5STEP = 1'b1
   } mode_e;

   function automatic int step_at(input int idx);
      case (idx)
         0:       return STEP1;
         1:       return STEP2;
         2:       return STEP3;
         3:       return STEP4;
         default: return STEP5;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] lfsr_next(input logic [CNT_W-1:0] s);
      return {s[CNT_W-2:0], s[14] ^ s[13]};
   endfunction

   // State the LFSR reaches after n advances from the seed; the sequence is
   // maximal length, so every count below 2^15-1 maps to a unique state.
   function automatic logic [CNT_W-1:0] bin2lfsr(input int n);
      logic [CNT_W-1:0] s;
      s = LFSR_SEED;
      for (int i = 0; i < n; i++) s = lfsr_next(s);
      return s;
   endfunction

`ifdef FRAME_LFSR_EN
   localparam logic [CNT_W-1:0] CNT_CLEAR = LFSR_SEED;

   function automatic logic [CNT_W-1:0] step_key(input int idx);
      return bin2lfsr(step_at(idx));
   endfunction

   function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c);
      return lfsr_next(c);
   endfunction
`else
   localparam logic [CNT_W-1:0] CNT_CLEAR = '0;

   function automatic logic [CNT_W-1:0] step_key(input int idx);
      return CNT_W'(step_at(idx));
   endfunction

   function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c);
      return c + CNT_W'(1);
   endfunction
`endif

endpackage

// File: rtl/frame_counter_if.sv
// Strobes and soft-clock outputs of the frame counter; the data bus stays a plain inout port.
interface frame_counter_if;
   logic W4017;
   logic n_R4015;
   logic nLFO1;
   logic nLFO2;
   logic INT;

   modport master (output W4017, n_R4015, input nLFO1, nLFO2, INT);
   modport slave  (input W4017, n_R4015, output nLFO1, nLFO2, INT);
endinterface

// File: rtl/frame_step_decode.sv
// Combinational step decode: compares the counter against the five step keys.
module frame_step_decode
   import apu_frame_pkg::*;
(
   input  logic [CNT_W-1:0] cnt,
   input  mode_e            mode,
   output logic             hit_q,
   output logic             hit_h,
   output logic             hit_irq,
   output logic             hit_wrap
);

   logic [NUM_STEPS-1:0] match;

   genvar gi;
   for (gi = 0; gi < NUM_STEPS; gi++) begin : g_match
      localparam logic [CNT_W-1:0] KEY = step_key(gi);
      assign match[gi] = (cnt == KEY);
   end

   // STEP4 ends the sequence in 4-step mode; in 5-step mode it is silent.
   assign hit_wrap = (mode == MODE_4STEP) ? match[3] : match[4];
   assign hit_irq  = (mode == MODE_4STEP) && match[3];
   assign hit_h    = match[1] | hit_wrap;
   assign hit_q    = match[0] | match[1] | match[2] | hit_wrap;

endmodule

// File: rtl/frame_counter.sv
// APU frame counter: quarter/half-frame soft clocks (nLFO1/nLFO2) and frame IRQ.
// Build with FRAME_LFSR_EN to run the step counter as an LFSR.
module frame_counter
   import apu_frame_pkg::*;
(
   input  logic           n_ACLK,
   input  logic           RES,
   inout  wire [7:0]      DB,
   frame_counter_if.slave bus
);

   genvar gi;
   for (gi = 0; gi < NUM_STEPS; gi++) begin : g_step_chk
      if (step_at(gi) < 0 || step_at(gi) >= (1 << CNT_W)) begin : g_bad
         $error("frame_counter: step constant %0d does not fit the counter", gi);
      end
   end

   logic [CNT_W-1:0] cnt_reg, cnt_next;
   mode_e            mode_reg;
   logic             irqdis_reg;
   logic             flag_reg, flag_next;
   logic [1:0]       pend_reg;
   logic             nlfo1_reg, nlfo2_reg;
   logic             hit_q, hit_h, hit_irq, hit_wrap;
   logic             force_pulse;

   wire unused_db = &{1'b0, DB[5:0]};

   frame_step_decode u_decode (
      .cnt      (cnt_reg),
      .mode     (mode_reg),
      .hit_q    (hit_q),
      .hit_h    (hit_h),
      .hit_irq  (hit_irq),
      .hit_wrap (hit_wrap)
   );

   // The delayed counter clear in 5-step mode also fires both soft clocks.
   assign force_pulse = pend_reg[1] && (mode_reg == MODE_5STEP);

   always_comb begin
      cnt_next = cnt_step(cnt_reg);
      if (hit_wrap || pend_reg[1]) cnt_next = CNT_CLEAR;

      flag_next = flag_reg;
      if (!bus.n_R4015) flag_next = 1'b0;
      if (hit_irq)      flag_next = 1'b1;
      if (irqdis_reg || (bus.W4017 && DB[6])) flag_next = 1'b0;
   end

   always_ff @(posedge n_ACLK) begin
      if (RES) begin
         cnt_reg    <= CNT_CLEAR;
         mode_reg   <= MODE_4STEP;
         irqdis_reg <= 1'b0;
         flag_reg   <= 1'b0;
         pend_reg   <= 2'b00;
         nlfo1_reg  <= 1'b1;
         nlfo2_reg  <= 1'b1;
      end else begin
         cnt_reg   <= cnt_next;
         flag_reg  <= flag_next;
         nlfo1_reg <= ~(hit_q | force_pulse);
         nlfo2_reg <= ~(hit_h | force_pulse);
         if (bus.W4017) begin
            mode_reg   <= mode_e'(DB[7]);
            irqdis_reg <= DB[6];
            pend_reg   <= 2'b01;
         end else begin
            pend_reg   <= {pend_reg[0], 1'b0};
         end
      end
   end

   assign bus.nLFO1 = nlfo1_reg;
   assign bus.nLFO2 = nlfo2_reg;
   assign bus.INT   = flag_reg;
   assign DB[6]     = bus.n_R4015 ? 1'bz : flag_reg;

endmodule

// File: tb/tb_frame_counter.sv
// Directed bench for frame_counter: pulse cycles, IRQ flag, $4017 writes and reset.
module tb_frame_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tb_db = 8'h00;
   logic       tb_db_en = 1'b0;
   wire  [7:0] db;

   assign db = tb_db_en ? tb_db : 8'bz;

   frame_counter_if bus();

   frame_counter dut (
      .n_ACLK (clk),
      .RES    (rst),
      .DB     (db),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int int_hi = 0;
   int q1[$];
   int q2[$];
   int exp_q[$];

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end else begin
         $display("check %s: %0d ok", tag, obs);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   // Advance n cycles, logging (cycle - base) of every low soft-clock cycle.
   task automatic run(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         tick();
         if (bus.nLFO1 === 1'b0) q1.push_back(cyc - base);
         if (bus.nLFO2 === 1'b0) q2.push_back(cyc - base);
         if (bus.INT === 1'b1) int_hi++;
      end
   endtask

   task automatic check_list(input string tag, input int got[$], input int exp[$]);
      check($sformatf("%s_count", tag), got.size(), exp.size());
      foreach (exp[i])
         check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : -1, exp[i]);
   endtask

   task automatic clear_log();
      q1.delete();
      q2.delete();
      int_hi = 0;
   endtask

   task automatic write_4017(input logic [7:0] val);
      bus.W4017 = 1'b1;
      tb_db     = val;
      tb_db_en  = 1'b1;
      tick();
      bus.W4017 = 1'b0;
      tb_db_en  = 1'b0;
   endtask

   initial begin
      bus.W4017   = 1'b0;
      bus.n_R4015 = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_nlfo1", bus.nLFO1, 1);
      check("rst_nlfo2", bus.nLFO2, 1);
      check("rst_int", bus.INT, 0);

      // 0x80 write at cycle 5, RES during W+1: pending clear must be dropped.
      rst = 1'b0;
      cyc = 0;
      repeat (5) tick();
      write_4017(8'h80);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cyc = 0;
      check("cancel_nlfo1", bus.nLFO1, 1);
      check("cancel_nlfo2", bus.nLFO2, 1);
      check("cancel_int", bus.INT, 0);

      // 4-step free run from cycle 0 (also shows mode=0 and no pulse at W+3).
      clear_log();
      run(18650, 0);
      exp_q = '{3729, 7457, 11186, 14915, 18644};
      check_list("t1_lfo1", q1, exp_q);
      exp_q = '{7457, 14915};
      check_list("t1_lfo2", q2, exp_q);
      check("t1_int_cycles", int_hi, 3736);

      // Status read clears the flag.
      check("t3_int_before", bus.INT, 1);
      bus.n_R4015 = 1'b0;
      #1;
      check("t3_db6", db[6], 1);
      tick();
      bus.n_R4015 = 1'b1;
      check("t3_int_after", bus.INT, 0);

      // Read held in the STEP4 cycle of the second period: set wins.
      while (cyc < 29829) tick();
      bus.n_R4015 = 1'b0;
      #1;
      check("t4_db6", db[6], 0);
      tick();
      bus.n_R4015 = 1'b1;
      check("t4_int_set_wins", bus.INT, 1);
      check("t4_nlfo1", bus.nLFO1, 0);
      check("t4_nlfo2", bus.nLFO2, 0);

      // 0x40 write at cycle 29830 with flag set: cleared, no IRQ for two periods.
      write_4017(8'h40);
      check("t5_int_clear", bus.INT, 0);
      clear_log();
      run(29849, 29830);
      exp_q = '{3732, 7460, 11189, 14918, 18647, 22375, 26104, 29833};
      check_list("t5_lfo1", q1, exp_q);
      exp_q = '{7460, 14918, 22375, 29833};
      check_list("t5_lfo2", q2, exp_q);
      check("t5_int_cycles", int_hi, 0);

      // 0x80 write at cycle 59680: immediate pulse at W+3, 5-step period.
      write_4017(8'h80);
      clear_log();
      run(18649, 59680);
      exp_q = '{3, 3732, 7460, 11189, 18644};
      check_list("t2_lfo1", q1, exp_q);
      exp_q = '{3, 7460, 18644};
      check_list("t2_lfo2", q2, exp_q);
      check("t2_int_cycles", int_hi, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
